// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder producing the 5-bit player/direction key code.
// Make codes map to 4*player+dir; the E0 prefix selects arrow keys over keypad keys.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [4:0]  IDLE_CODE      = 5'd31
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic       start_pulse,
  output logic [7:0] scan_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  rx_state_t     state_r;
  logic [1:0]    clk_sync_r;
  logic [1:0]    dat_sync_r;
  logic          clk_prev_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] timeout_r;
  logic          ext_r;
  logic          brk_r;
  logic          fall_s;
  logic          dat_s;
  logic [5:0]    map_s;

  // Odd parity holds when the nine bits contain an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Returns {hit, code}; E0-prefixed arrows and bare keypad keys share byte values.
  function automatic logic [5:0] map_key(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h01D:  map_key = {1'b1, 5'd0};
      9'h01B:  map_key = {1'b1, 5'd1};
      9'h01C:  map_key = {1'b1, 5'd2};
      9'h023:  map_key = {1'b1, 5'd3};
      9'h175:  map_key = {1'b1, 5'd4};
      9'h172:  map_key = {1'b1, 5'd5};
      9'h16B:  map_key = {1'b1, 5'd6};
      9'h174:  map_key = {1'b1, 5'd7};
      9'h043:  map_key = {1'b1, 5'd8};
      9'h042:  map_key = {1'b1, 5'd9};
      9'h03B:  map_key = {1'b1, 5'd10};
      9'h04B:  map_key = {1'b1, 5'd11};
      9'h075:  map_key = {1'b1, 5'd12};
      9'h073:  map_key = {1'b1, 5'd13};
      9'h06B:  map_key = {1'b1, 5'd14};
      9'h074:  map_key = {1'b1, 5'd15};
      default: map_key = {1'b0, IDLE_CODE};
    endcase
  endfunction

  assign fall_s = ~clk_sync_r[1] & clk_prev_r;
  assign dat_s  = dat_sync_r[1];
  assign map_s  = map_key(ext_r, scan_byte);

  // Two-flop synchronisers for the asynchronous PS/2 lines, plus edge history.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], PS2_CLK};
      dat_sync_r <= {dat_sync_r[0], PS2_DAT};
      clk_prev_r <= clk_sync_r[1];
    end
  end

  // Frame receiver: start, 8 data bits LSB first, odd parity, stop, with inactivity timeout.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      parity_r    <= 1'b0;
      timeout_r   <= '0;
      scan_byte   <= 8'h00;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (state_r != ST_IDLE && !fall_s && timeout_r == TIMEOUT_LAST) begin
        // A stalled partial frame is dropped without reporting an error.
        state_r   <= ST_IDLE;
        timeout_r <= '0;
      end else begin
        if (fall_s || state_r == ST_IDLE) begin
          timeout_r <= '0;
        end else begin
          timeout_r <= timeout_r + TW'(1);
        end
        if (fall_s) begin
          case (state_r)
            ST_IDLE: begin
              bit_cnt_r <= 3'd0;
              if (!dat_s) begin
                state_r <= ST_DATA;
              end else begin
                state_r <= ST_IDLE;
              end
            end
            ST_DATA: begin
              shift_r   <= {dat_s, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= ST_PARITY;
              end else begin
                state_r <= ST_DATA;
              end
            end
            ST_PARITY: begin
              parity_r <= dat_s;
              state_r  <= ST_STOP;
            end
            ST_STOP: begin
              if (dat_s && parity_ok(shift_r, parity_r)) begin
                scan_byte  <= shift_r;
                byte_valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
              state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Make/break decoder acting on each good byte; outputs land one cycle after byte_valid.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      KEY_PRESSED <= IDLE_CODE;
      key_valid   <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      KEY_PRESSED <= IDLE_CODE;
      key_valid   <= 1'b0;
      start_pulse <= 1'b0;
      if (byte_valid) begin
        if (scan_byte == 8'hE0) begin
          ext_r <= 1'b1;
        end else if (scan_byte == 8'hF0) begin
          brk_r <= 1'b1;
        end else if (brk_r) begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end else begin
          if (!ext_r && scan_byte == 8'h29) begin
            start_pulse <= 1'b1;
          end else if (map_s[5]) begin
            KEY_PRESSED <= map_s[4:0];
            key_valid   <= 1'b1;
          end else begin
            KEY_PRESSED <= IDLE_CODE;
          end
          ext_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised self-checking bench: drives PS/2 frames and compares decoded events to a table model.
module tb_ps2_key_decoder;

  localparam int H = 8;
  localparam logic [4:0] IDLE = 5'd31;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [4:0] KEY_PRESSED;
  logic       key_valid, start_pulse, byte_valid, frame_error;
  logic [7:0] scan_byte;

  ps2_key_decoder dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .KEY_PRESSED(KEY_PRESSED), .key_valid(key_valid), .start_pulse(start_pulse),
    .scan_byte(scan_byte), .byte_valid(byte_valid), .frame_error(frame_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;

  // Event monitor: counts strobes and timestamps them; written only here.
  int cyc = 0, n_bv = 0, n_fe = 0, n_kv = 0, n_sp = 0, n_bad = 0;
  int bv_cyc = 0, kv_cyc = 0, sp_cyc = 0;
  logic [4:0] kv_code = 5'd0;
  always @(negedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (byte_valid) begin n_bv <= n_bv + 1; bv_cyc <= cyc; end
    if (frame_error) n_fe <= n_fe + 1;
    if (key_valid) begin n_kv <= n_kv + 1; kv_cyc <= cyc; kv_code <= KEY_PRESSED; end
    if (start_pulse) begin n_sp <= n_sp + 1; sp_cyc <= cyc; end
    if ((key_valid != (KEY_PRESSED != IDLE)) || (key_valid && start_pulse) ||
        (byte_valid && frame_error))
      n_bad <= n_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: key table indexed by ext*256+byte, plus prefix flags.
  int  keymap[int];
  bit  m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] m_scan = 8'h00;

  task automatic model_byte(input logic [7:0] b, output bit kv, output int code, output bit sp);
    kv = 1'b0; sp = 1'b0; code = IDLE;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
    else begin
      if (keymap.exists(int'(m_ext) * 256 + int'(b))) begin
        kv = 1'b1; code = keymap[int'(m_ext) * 256 + int'(b)];
      end else if (!m_ext && b == 8'h29) sp = 1'b1;
      m_ext = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nedges);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      @(negedge CLOCK_50) PS2_DAT = fr[i];
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    repeat (H) @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
  endtask

  task automatic do_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int s_bv, s_fe, s_kv, s_sp, code;
    bit kv, sp;
    s_bv = n_bv; s_fe = n_fe; s_kv = n_kv; s_sp = n_sp;
    send_frame(b, bad_par, bad_stop, 11);
    repeat (10) @(negedge CLOCK_50);
    if (bad_par || bad_stop) begin
      check_eq("err_fe", n_fe - s_fe, 1);
      check_eq("err_bv", n_bv - s_bv, 0);
      check_eq("err_scan", scan_byte, m_scan);
      check_eq("err_kv", n_kv - s_kv, 0);
      check_eq("err_sp", n_sp - s_sp, 0);
    end else begin
      m_scan = b;
      model_byte(b, kv, code, sp);
      check_eq("bv_cnt", n_bv - s_bv, 1);
      check_eq("fe_cnt", n_fe - s_fe, 0);
      check_eq("scan", scan_byte, b);
      check_eq("kv_cnt", n_kv - s_kv, kv);
      check_eq("sp_cnt", n_sp - s_sp, sp);
      if (kv) begin
        check_eq("kv_code", kv_code, code);
        check_eq("kv_lat", kv_cyc - bv_cyc, 1);
      end
      if (sp) check_eq("sp_lat", sp_cyc - bv_cyc, 1);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50) reset = 1'b1;
    @(negedge CLOCK_50) reset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_scan = 8'h00;
    check_eq("rst_key", KEY_PRESSED, IDLE);
    check_eq("rst_kv", key_valid, 0);
    check_eq("rst_sp", start_pulse, 0);
    check_eq("rst_bv", byte_valid, 0);
    check_eq("rst_fe", frame_error, 0);
    check_eq("rst_scan", scan_byte, 8'h00);
  endtask

  logic [7:0] pool [19] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h43,
                            8'h42, 8'h3B, 8'h4B, 8'h73, 8'h29, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h5A};

  initial begin
    int s_fe, s_bv;
    logic [7:0] b;
    keymap[16'h01D] = 0;  keymap[16'h01B] = 1;  keymap[16'h01C] = 2;  keymap[16'h023] = 3;
    keymap[16'h175] = 4;  keymap[16'h172] = 5;  keymap[16'h16B] = 6;  keymap[16'h174] = 7;
    keymap[16'h043] = 8;  keymap[16'h042] = 9;  keymap[16'h03B] = 10; keymap[16'h04B] = 11;
    keymap[16'h075] = 12; keymap[16'h073] = 13; keymap[16'h06B] = 14; keymap[16'h074] = 15;

    repeat (3) @(negedge CLOCK_50);
    apply_reset();

    do_byte(8'h1D, 0, 0);
    do_byte(8'hE0, 0, 0); do_byte(8'h74, 0, 0);
    do_byte(8'h74, 0, 0);
    do_byte(8'hE0, 0, 0); do_byte(8'hF0, 0, 0); do_byte(8'h74, 0, 0);
    do_byte(8'h74, 0, 0);
    do_byte(8'h43, 1, 0); do_byte(8'h4B, 0, 0);
    do_byte(8'h1B, 0, 1);

    // Abandoned partial frame must time out silently.
    s_fe = n_fe; s_bv = n_bv;
    send_frame(8'h55, 0, 0, 5);
    repeat (50050) @(negedge CLOCK_50);
    check_eq("to_fe", n_fe - s_fe, 0);
    check_eq("to_bv", n_bv - s_bv, 0);
    do_byte(8'h29, 0, 0);

    do_byte(8'hE0, 0, 0);
    apply_reset();
    do_byte(8'h75, 0, 0);

    do_byte(8'h1C, 0, 0);
    send_frame(8'hAA, 0, 0, 4);
    apply_reset();
    do_byte(8'h23, 0, 0);

    // Idle-state edge with data high is ignored.
    s_fe = n_fe; s_bv = n_bv;
    @(negedge CLOCK_50) PS2_DAT = 1'b1;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (H) @(negedge CLOCK_50);
    check_eq("glitch_fe", n_fe - s_fe, 0);
    check_eq("glitch_bv", n_bv - s_bv, 0);
    do_byte(8'h23, 0, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 18)];
      case ($urandom_range(0, 9))
        0:       do_byte(b, 1, 0);
        1:       do_byte(b, 0, 1);
        default: do_byte(b, 0, 0);
      endcase
    end

    check_eq("invariants", n_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
